// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: stage occupancy states, per-boundary bundle
// widths and the packed field bundles carried between IF/ID/EXE/MEM/WB.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } stage_state_t;

    localparam int IF_ID_W   = 64;
    localparam int ID_EXE_W  = 177;
    localparam int EXE_MEM_W = 134;
    localparam int MEM_WB_W  = 135;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } if_id_t;

    typedef struct packed {
        logic [3:0]  alu_op;
        logic        alu_src;
        logic        reg_write;
        logic        mem_write;
        logic        mem_to_reg;
        logic        cache_en;
        logic        is_lb_sb;
        logic [1:0]  jump;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] inst;
    } id_exe_t;

    // jump is two bits wide (jump kind), which brings this bundle to 134 bits
    typedef struct packed {
        logic        mem_write;
        logic [31:0] alu_result;
        logic        is_lb_sb;
        logic [31:0] rt_data;
        logic        cache_en;
        logic        mem_to_reg;
        logic [1:0]  jump;
        logic [31:0] pc;
        logic [31:0] inst;
    } exe_mem_t;

    typedef struct packed {
        logic        reg_write;
        logic        mem_to_reg;
        logic [31:0] mem_data;
        logic [31:0] alu_result;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] inst;
    } mem_wb_t;

    function automatic logic [1:0] occ_of(input stage_state_t s);
        case (s)
            ONE:     occ_of = 2'd1;
            FULL:    occ_of = 2'd2;
            default: occ_of = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
// Used for stage stall accounting and the performance counters.
module pipe_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_b,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            count_reg <= '0;
        end else if (inc && (count_reg != {W{1'b1}})) begin
            count_reg <= count_reg + W'(1);
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register with valid/ready handshake, optional 2-entry skid,
// freeze, flush with bubble insertion and a saturating stall counter.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int               WIDTH  = EXE_MEM_W,
    parameter bit               SKID   = 1'b1,
    parameter logic [WIDTH-1:0] BUBBLE = '0,
    parameter int               CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             freeze,
    input  logic             flush,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt
);

    stage_state_t     state_reg, state_next;
    logic [WIDTH-1:0] main_reg, main_next;
    logic [WIDTH-1:0] skid_reg, skid_next;
    logic             push, pop, stall_inc;

    assign out_valid = (state_reg != EMPTY);
    assign out_data  = out_valid ? main_reg : BUBBLE;
    assign occupancy = occ_of(state_reg);

    generate
        if (SKID) begin : g_skid
            // Registered ready: derived from the next state so it never
            // depends on same-cycle consumer inputs.
            logic in_ready_reg;
            always_ff @(posedge clk or negedge rst_b) begin
                if (!rst_b) begin
                    in_ready_reg <= 1'b1;
                end else begin
                    in_ready_reg <= (state_next != FULL);
                end
            end
            assign in_ready = in_ready_reg;
        end else begin : g_single
            assign in_ready = ~out_valid | (out_ready & ~freeze);
        end
    endgenerate

    assign push      = in_valid & in_ready & ~freeze & ~flush;
    assign pop       = out_valid & out_ready & ~freeze & ~flush;
    assign stall_inc = out_valid & (~out_ready | freeze) & ~flush;

    always_comb begin
        state_next = state_reg;
        main_next  = main_reg;
        skid_next  = skid_reg;
        if (flush) begin
            state_next = EMPTY;
            main_next  = BUBBLE;
            skid_next  = BUBBLE;
        end else begin
            case (state_reg)
                EMPTY: begin
                    if (push) begin
                        state_next = ONE;
                        main_next  = in_data;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        main_next = in_data;
                    end else if (push) begin
                        if (SKID) begin
                            state_next = FULL;
                            skid_next  = in_data;
                        end
                    end else if (pop) begin
                        state_next = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state_next = ONE;
                        main_next  = skid_reg;
                    end
                end
                default: begin
                    state_next = EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_reg <= EMPTY;
            main_reg  <= BUBBLE;
            skid_reg  <= BUBBLE;
        end else begin
            state_reg <= state_next;
            main_reg  <= main_next;
            skid_reg  <= skid_next;
        end
    end

    pipe_sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_b (rst_b),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline-stage register with a valid/ready handshake, a 2-entry skid buffer, global freeze, synchronous flush with bubble insertion, and a saturating stall counter. It is the generic successor to the fixed per-stage latches between IF/ID/EXE/MEM/WB. Each stage boundary instantiates it with the packed field bundle for that boundary. It supports backpressure from stalling consumers such as the cache, which the old freeze-only latches cannot absorb without losing data.

## Interface
Parameters:
- WIDTH, 134, packed payload width (EXE→MEM bundle: mem_write, alu_result, is_LB_SB, rt_data, cache_en, mem_to_reg, jump, pc, inst).
- SKID, 1, 1 = 2-entry skid (registered in_ready); 0 = single entry (combinational in_ready).
- BUBBLE, '0, payload value presented whenever the stage holds no valid entry.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_b  in  1  reset, asynchronous, active-low.
- in_valid  in  1  producer has data.
- in_ready  out  1  stage can accept.
- in_data  in  WIDTH  producer payload.
- out_valid  out  1  stage holds valid entry.
- out_ready  in  1  consumer accepts.
- out_data  out  WIDTH  head entry payload.
- freeze  in  1  global stall; blocks both handshakes.
- flush  in  1  kill all contents (branch/jump squash).
- occupancy  out  2  entries held (0..2).
- stall_cnt  out  CNT_W  saturating count of stalled cycles.

## Operation
- Push = in_valid & in_ready & ~freeze & ~flush; pop = out_valid & out_ready & ~freeze & ~flush.
- States EMPTY, ONE, FULL (FULL only when SKID=1). Storage: main (head) and skid.
- EMPTY: push → ONE, main ← in_data.
- ONE: push&pop → ONE, main ← in_data. Push only → FULL, skid ← in_data (SKID=1). Pop only → EMPTY.
- FULL: no push possible. Pop → ONE, main ← skid.
- SKID=0: in_ready = ~out_valid | (out_ready & ~freeze). Push in ONE without pop is impossible.
- SKID=1: in_ready = (state != FULL), registered. It depends on no same-cycle input.
- flush: next state EMPTY, main/skid ← BUBBLE. Any same-cycle push or pop is discarded and not counted. flush dominates freeze.
- freeze without flush: state, data and stall counter unchanged except as stated under stall_cnt. in_ready/out_valid still reflect state.
- out_valid = (state != EMPTY); out_data = main, BUBBLE when EMPTY. occupancy = 0/1/2 for EMPTY/ONE/FULL.
- stall_cnt increments when out_valid & (~out_ready | freeze) & ~flush. It saturates at 2^CNT_W−1 (no wrap) and is cleared only by reset.
- Strict FIFO order; no entry duplicated or dropped except on flush.

## Timing
- Reset (async assert, sync to next edge on release): state EMPTY, out_valid 0, out_data BUBBLE, in_ready 1, occupancy 0, stall_cnt 0.
- Latency: in_data pushed at edge N appears on out_data/out_valid after edge N (1 cycle), from either EMPTY or ONE-with-pop.
- Throughput 1 entry/cycle sustained when out_ready=1.
- With SKID=1, out_ready deasserting costs no data: up to one extra push lands in skid. in_ready drops the cycle after FULL is entered.
- Recovery FULL → ONE on the first pop. in_ready rises the following cycle.
- Reset mid-operation: all entries lost immediately; outputs as reset values while rst_b low.

## Structure
- Shared package pipe_pkg: stage_state_t enum {EMPTY, ONE, FULL}, per-boundary bundle widths (IF_ID_W, ID_EXE_W, EXE_MEM_W=134, MEM_WB_W), and packed struct typedefs for each bundle.
- Sub-module pipe_sat_counter (parameter W; inc, clk, rst_b → count) for stall_cnt; reused by the perf counters.
- No $display in RTL; tracing lives in the bench.

## Test plan
- Reset with in_valid=1, in_data=0xA5…: out_valid=0, out_data=BUBBLE, in_ready=1, occupancy=0 until first edge after rst_b=1.
- Stream 0x1..0x8, out_ready=1: out_data=0x1 one cycle after first push, then one per cycle, in order, stall_cnt stays 0.
- SKID=1: push 0x10, 0x11 with out_ready=0: occupancy=2, in_ready=0, stall_cnt increments. Then out_ready=1: outputs 0x10, 0x11 in order, and in_ready returns 1 the cycle after the first pop.
- flush in FULL with simultaneous in_valid (0x22): next cycle occupancy=0, out_data=BUBBLE, 0x22 never appears.
- freeze=1 for 3 cycles while ONE with out_ready=1, in_valid=1: no pop or push, out_data held, stall_cnt +3.
- CNT_W=4, hold stall for 20 cycles: stall_cnt saturates at 15.
